interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Sequences the internal datapath through the 6502-style interrupt/reset entry: dummy cycle, push PCH/PCL/PSR to stack page 1, vector fetch, PC load.
- Owns the datapath flag vector while busy; the instruction decoder owns it otherwise.
- Sits beside the decoder; a top-level mux selects `flags_out` whenever `busy`=1.
- Arbitrates RESET, NMI, IRQ and BRK, and selects vector FFFC, FFFA or FFFE.

Parameters:
- FLAG_COUNT, 101, width of datapath flag vector (must equal package constant).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- nmi  in  1  NMI request, active-high, edge-sensitive (rising edge latched).
- irq  in  1  IRQ request, active-high, level-sensitive.
- brk_req  in  1  one-cycle pulse from decoder on BRK opcode, coincident with instr_boundary.
- instr_boundary  in  1  decoder last-cycle indicator; only point where non-reset sequences start.
- psr_i  in  1  PSR interrupt-disable bit.
- flags_out  out  FLAG_COUNT  datapath control flags, indexed by package constants.
- mem_write  out  1  external write strobe (push cycles only).
- busy  out  1  sequencer owns datapath.
- seq_done  out  1  one-cycle pulse on final cycle.
- vector_sel  out  2  0=NONE,1=NMI(FFFA),2=RESET(FFFC),3=IRQ/BRK(FFFE); held while busy.

Behaviour:
- Reset values: flags_out=0, mem_write=0, busy=0, seq_done=0, vector_sel=NONE, state=IDLE, nmi_pending=0, nmi_prev=0, reset_pending=1.
  - Reset mid-sequence aborts immediately to these values.
- NMI edge detect: nmi & ~nmi_prev sets nmi_pending.
  - nmi_pending is cleared only when an NMI vector is committed in VEC_LO.
  - An edge arriving while busy is kept pending.
- Start, in IDLE:
  - reset_pending=1 starts on the first clock after rst falls; instr_boundary is not required.
  - Otherwise, when instr_boundary=1, priority is nmi_pending > brk_req > (irq & ~psr_i).
  - The start cycle registers the source and enters PREP next cycle.
  - irq with psr_i=1 is ignored; BRK is never masked.
  - brk_req while busy is ignored.
- States and flags (one state per cycle):
  - PREP: busy=1; dummy cycle, flags 0 except SET_ADL_TO_SP, LOAD_ABL, SET_ADH_TO_ONE, LOAD_ABH (stack address 01:SP).
  - PUSH_PCH: SET_DB_TO_PCH, LOAD_DOR, mem_write=1. SP decrement: SET_SB_TO_SP, SET_INPUT_A_TO_SB, SET_DB_HIGH, SET_INPUT_B_TO_DB, ALU_ADD, LOAD_ALU.
  - PUSH_PCL: SET_SB_TO_ALU, LOAD_SP, re-address stack, SET_DB_TO_PCL, LOAD_DOR, mem_write=1, and next SP decrement.
  - PUSH_PSR: as PUSH_PCL with SET_DB_TO_PSR. Adds SET_PSR_OUTPUT_BRK_HIGH for BRK only.
  - VEC_LO: SET_SB_TO_ALU, LOAD_SP. Address vector low via SET_ADL_FA/FC/FE plus SET_ADH_FF, LOAD_ABL, LOAD_ABH. LOAD_INTERUPT_PSR_FLAG.
    - NMI hijack: if source is IRQ/BRK and nmi_pending=1 on entry, vector becomes FFFA, vector_sel becomes NMI, and nmi_pending clears.
  - VEC_HI: SET_DB_TO_DATA, SET_INPUT_B_TO_DB, SET_INPUT_A_TO_LOW, ALU_ADD, LOAD_ALU (capture low byte). Address vector+1 via SET_ADL_FB/FD/FF, LOAD_ABL.
  - LOAD_PC: SET_ADL_TO_ALU, SET_ADH_TO_DATA, LOAD_PC, seq_done=1; next state IDLE, busy=0.
- RESET source: the three push states keep mem_write=0 and omit LOAD_DOR (reads only); SP still decrements. reset_pending clears on entry to PREP.
- Latency: start cycle + 7 busy cycles; seq_done on the 7th busy cycle. Back-to-back sequences need a new instr_boundary after IDLE.
- Outputs are registered from state: flags_out is a combinational decode of the registered state/source only (no input-to-output paths).

Decomposition:
- Shared package cpu_flags_pkg:
  - flag index constants (LOAD_ABL, SET_ADL_FA, ...), FLAG_COUNT;
  - typedef enum seq_state_t {IDLE, PREP, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI, LOAD_PC};
  - typedef enum int_src_t {SRC_NONE, SRC_NMI, SRC_RESET, SRC_IRQ, SRC_BRK}.
- One sub-module, interrupt_arbiter: NMI edge latch, reset_pending, priority select, hijack decision.
- The FSM and flag decode stay in interrupt_sequencer.

Test Plan:
- Release rst, no other inputs:
  - busy rises the next cycle and vector_sel=RESET;
  - mem_write stays 0 for all 7 cycles;
  - SET_ADL_FC is asserted in VEC_LO, SET_ADL_FD in VEC_HI;
  - seq_done fires at busy cycle 7.
- irq=1, psr_i=0, pulse instr_boundary:
  - mem_write=1 exactly in PUSH_PCH/PUSH_PCL/PUSH_PSR;
  - vector FFFE, LOAD_INTERUPT_PSR_FLAG in VEC_LO;
  - SET_PSR_OUTPUT_BRK_HIGH never asserted.
- irq=1, psr_i=1, instr_boundary pulses for 10 cycles -> busy stays 0. brk_req with psr_i=1 -> sequence runs, BRK bit set in PUSH_PSR, vector FFFE.
- nmi rising edge and irq together at a boundary -> NMI wins, vector FFFA, nmi_pending cleared; a second boundary with irq still high starts an IRQ sequence.
- BRK accepted, nmi edge during PUSH_PCL -> VEC_LO uses SET_ADL_FA, vector_sel=NMI, BRK bit still pushed, nmi_pending cleared.
- Assert rst during PUSH_PCL -> all outputs 0 asynchronously; after release a full RESET sequence runs.

Source files
------------

// File: rtl/cpu_flags_pkg.sv
// Shared datapath flag indices and interrupt sequencer types.
// Flag bits not listed here belong to the instruction decoder.
package cpu_flags_pkg;
    localparam int FLAG_COUNT = 101;

    localparam int LOAD_ABL                = 0;
    localparam int LOAD_ABH                = 1;
    localparam int SET_ADL_TO_SP           = 2;
    localparam int SET_ADH_TO_ONE          = 3;
    localparam int SET_DB_TO_PCH           = 4;
    localparam int SET_DB_TO_PCL           = 5;
    localparam int SET_DB_TO_PSR           = 6;
    localparam int LOAD_DOR                = 7;
    localparam int SET_SB_TO_SP            = 8;
    localparam int SET_INPUT_A_TO_SB       = 9;
    localparam int SET_DB_HIGH             = 10;
    localparam int SET_INPUT_B_TO_DB       = 11;
    localparam int ALU_ADD                 = 12;
    localparam int LOAD_ALU                = 13;
    localparam int SET_SB_TO_ALU           = 14;
    localparam int LOAD_SP                 = 15;
    localparam int SET_PSR_OUTPUT_BRK_HIGH = 16;
    localparam int SET_ADL_FA              = 17;
    localparam int SET_ADL_FB              = 18;
    localparam int SET_ADL_FC              = 19;
    localparam int SET_ADL_FD              = 20;
    localparam int SET_ADL_FE              = 21;
    localparam int SET_ADL_FF              = 22;
    localparam int SET_ADH_FF              = 23;
    localparam int LOAD_INTERUPT_PSR_FLAG  = 24;
    localparam int SET_DB_TO_DATA          = 25;
    localparam int SET_INPUT_A_TO_LOW      = 26;
    localparam int SET_ADL_TO_ALU          = 27;
    localparam int SET_ADH_TO_DATA         = 28;
    localparam int LOAD_PC                 = 29;

    typedef enum logic [2:0] {
        IDLE, PREP, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI, S_LOAD_PC
    } seq_state_t;

    typedef enum logic [2:0] {
        SRC_NONE, SRC_NMI, SRC_RESET, SRC_IRQ, SRC_BRK
    } int_src_t;

    function automatic logic [1:0] vec_of(int_src_t s);
        case (s)
            SRC_NMI:          return 2'd1;
            SRC_RESET:        return 2'd2;
            SRC_IRQ, SRC_BRK: return 2'd3;
            default:          return 2'd0;
        endcase
    endfunction
endpackage

// File: rtl/interrupt_arbiter.sv
// NMI edge latch, pending reset, start priority and late-NMI hijack decision.
module interrupt_arbiter
    import cpu_flags_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     nmi,
    input  logic     irq,
    input  logic     brk_req,
    input  logic     instr_boundary,
    input  logic     psr_i,
    input  logic     idle,
    input  int_src_t cur_src,
    input  logic     nmi_commit,
    output logic     start,
    output int_src_t start_src,
    output logic     hijack
);
    logic nmi_prev, nmi_pending, reset_pending, nmi_edge, nmi_req;

    // A same-cycle edge counts as pending so it can win the boundary it arrives on.
    assign nmi_edge = nmi & ~nmi_prev;
    assign nmi_req  = nmi_pending | nmi_edge;

    always_comb begin
        start_src = SRC_NONE;
        if (reset_pending)
            start_src = SRC_RESET;
        else if (instr_boundary) begin
            if (nmi_req)            start_src = SRC_NMI;
            else if (brk_req)       start_src = SRC_BRK;
            else if (irq && !psr_i) start_src = SRC_IRQ;
        end
    end

    assign start  = idle && (start_src != SRC_NONE);
    assign hijack = nmi_req && (cur_src == SRC_IRQ || cur_src == SRC_BRK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_prev      <= 1'b0;
            nmi_pending   <= 1'b0;
            reset_pending <= 1'b1;
        end else begin
            nmi_prev <= nmi;
            if (nmi_edge)        nmi_pending <= 1'b1;
            else if (nmi_commit) nmi_pending <= 1'b0;
            if (start && start_src == SRC_RESET) reset_pending <= 1'b0;
        end
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt/reset entry sequencer: stack pushes, vector fetch and PC load.
// Outputs decode only registered state/source, so there is no input-to-output path.
module interrupt_sequencer #(
    parameter int FLAG_COUNT = cpu_flags_pkg::FLAG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nmi,
    input  logic                  irq,
    input  logic                  brk_req,
    input  logic                  instr_boundary,
    input  logic                  psr_i,
    output logic [FLAG_COUNT-1:0] flags_out,
    output logic                  mem_write,
    output logic                  busy,
    output logic                  seq_done,
    output logic [1:0]            vector_sel
);
    import cpu_flags_pkg::*;

    seq_state_t state;
    int_src_t   src, start_src;
    logic       start, hijack;

    interrupt_arbiter u_arb (
        .clk            (clk),
        .rst            (rst),
        .nmi            (nmi),
        .irq            (irq),
        .brk_req        (brk_req),
        .instr_boundary (instr_boundary),
        .psr_i          (psr_i),
        .idle           (state == IDLE),
        .cur_src        (src),
        .nmi_commit     (state == VEC_LO && src == SRC_NMI),
        .start          (start),
        .start_src      (start_src),
        .hijack         (hijack)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            src   <= SRC_NONE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= PREP;
                    src   <= start_src;
                end
                PREP:     state <= PUSH_PCH;
                PUSH_PCH: state <= PUSH_PCL;
                PUSH_PCL: state <= PUSH_PSR;
                PUSH_PSR: begin
                    state <= VEC_LO;
                    if (hijack) src <= SRC_NMI;
                end
                VEC_LO:   state <= VEC_HI;
                VEC_HI:   state <= S_LOAD_PC;
                default: begin
                    state <= IDLE;
                    src   <= SRC_NONE;
                end
            endcase
        end
    end

    logic [FLAG_COUNT-1:0] f;
    logic                  push;

    always_comb begin
        f    = '0;
        push = state inside {PUSH_PCH, PUSH_PCL, PUSH_PSR};
        if (state inside {PREP, PUSH_PCL, PUSH_PSR}) begin
            f[SET_ADL_TO_SP]  = 1'b1;
            f[LOAD_ABL]       = 1'b1;
            f[SET_ADH_TO_ONE] = 1'b1;
            f[LOAD_ABH]       = 1'b1;
        end
        // SP-1 is computed in each push and written back on the following cycle.
        if (push) begin
            f[SET_SB_TO_SP]      = 1'b1;
            f[SET_INPUT_A_TO_SB] = 1'b1;
            f[SET_DB_HIGH]       = 1'b1;
            f[SET_INPUT_B_TO_DB] = 1'b1;
            f[ALU_ADD]           = 1'b1;
            f[LOAD_ALU]          = 1'b1;
            f[LOAD_DOR]          = (src != SRC_RESET);
        end
        if (state inside {PUSH_PCL, PUSH_PSR, VEC_LO}) begin
            f[SET_SB_TO_ALU] = 1'b1;
            f[LOAD_SP]       = 1'b1;
        end
        case (state)
            PUSH_PCH: f[SET_DB_TO_PCH] = 1'b1;
            PUSH_PCL: f[SET_DB_TO_PCL] = 1'b1;
            PUSH_PSR: begin
                f[SET_DB_TO_PSR]           = 1'b1;
                f[SET_PSR_OUTPUT_BRK_HIGH] = (src == SRC_BRK);
            end
            VEC_LO: begin
                f[SET_ADL_FA]             = (src == SRC_NMI);
                f[SET_ADL_FC]             = (src == SRC_RESET);
                f[SET_ADL_FE]             = (src == SRC_IRQ || src == SRC_BRK);
                f[SET_ADH_FF]             = 1'b1;
                f[LOAD_ABL]               = 1'b1;
                f[LOAD_ABH]               = 1'b1;
                f[LOAD_INTERUPT_PSR_FLAG] = 1'b1;
            end
            VEC_HI: begin
                f[SET_DB_TO_DATA]     = 1'b1;
                f[SET_INPUT_B_TO_DB]  = 1'b1;
                f[SET_INPUT_A_TO_LOW] = 1'b1;
                f[ALU_ADD]            = 1'b1;
                f[LOAD_ALU]           = 1'b1;
                f[SET_ADL_FB]         = (src == SRC_NMI);
                f[SET_ADL_FD]         = (src == SRC_RESET);
                f[SET_ADL_FF]         = (src == SRC_IRQ || src == SRC_BRK);
                f[LOAD_ABL]           = 1'b1;
            end
            S_LOAD_PC: begin
                f[SET_ADL_TO_ALU]  = 1'b1;
                f[SET_ADH_TO_DATA] = 1'b1;
                f[LOAD_PC]         = 1'b1;
            end
            default: ;
        endcase
    end

    assign flags_out  = f;
    assign mem_write  = push && (src != SRC_RESET);
    assign busy       = (state != IDLE);
    assign seq_done   = (state == S_LOAD_PC);
    assign vector_sel = vec_of(src);
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench: directed vector table, corner-case sequences, random run vs model.
module tb_interrupt_sequencer;
    import cpu_flags_pkg::*;

    logic clk = 1'b0;
    logic rst, nmi, irq, brk_req, instr_boundary, psr_i;
    logic [FLAG_COUNT-1:0] flags_out;
    logic mem_write, busy, seq_done;
    logic [1:0] vector_sel;

    interrupt_sequencer #(.FLAG_COUNT(FLAG_COUNT)) dut (
        .clk(clk), .rst(rst), .nmi(nmi), .irq(irq), .brk_req(brk_req),
        .instr_boundary(instr_boundary), .psr_i(psr_i), .flags_out(flags_out),
        .mem_write(mem_write), .busy(busy), .seq_done(seq_done), .vector_sel(vector_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a cycle number within the entry sequence (0 = idle, 1..7 = busy)
    // plus the interrupt source, driven by the arbitration rules.
    localparam int M_NONE = 0, M_NMI = 1, M_RST = 2, M_IRQ = 3, M_BRK = 4;
    int m_step, m_src;
    bit m_np, m_prev, m_rp;

    task automatic model_reset();
        m_step = 0; m_src = M_NONE; m_np = 0; m_prev = 0; m_rp = 1;
    endtask

    task automatic model_step();
        bit edge_seen, req, clr;
        if (rst) begin model_reset(); return; end
        edge_seen = nmi && !m_prev;
        req = m_np || edge_seen;
        clr = 0;
        if (m_step == 0) begin
            if (m_rp) begin m_src = M_RST; m_rp = 0; m_step = 1; end
            else if (instr_boundary) begin
                if (req)               begin m_src = M_NMI; m_step = 1; end
                else if (brk_req)      begin m_src = M_BRK; m_step = 1; end
                else if (irq && !psr_i) begin m_src = M_IRQ; m_step = 1; end
            end
        end else if (m_step == 7) begin
            m_step = 0; m_src = M_NONE;
        end else begin
            if (m_step == 4 && (m_src == M_IRQ || m_src == M_BRK) && req) m_src = M_NMI;
            if (m_step == 5 && m_src == M_NMI) clr = 1;
            m_step++;
        end
        m_np = (m_np && !clr) || edge_seen;
        m_prev = nmi;
    endtask

    function automatic logic [1:0] m_vec(int s);
        if (s == M_NMI) return 2'd1;
        if (s == M_RST) return 2'd2;
        if (s == M_IRQ || s == M_BRK) return 2'd3;
        return 2'd0;
    endfunction

    // Datapath moves for each busy cycle of the entry sequence.
    function automatic logic [FLAG_COUNT-1:0] m_flags(int step, int s);
        logic [FLAG_COUNT-1:0] v = '0;
        bit writes = (s != M_RST);
        bit irqv = (s == M_IRQ || s == M_BRK);
        if (step == 1 || step == 3 || step == 4) begin
            v[SET_ADL_TO_SP] = 1; v[LOAD_ABL] = 1; v[SET_ADH_TO_ONE] = 1; v[LOAD_ABH] = 1;
        end
        if (step >= 2 && step <= 4) begin
            v[SET_SB_TO_SP] = 1; v[SET_INPUT_A_TO_SB] = 1; v[SET_DB_HIGH] = 1;
            v[SET_INPUT_B_TO_DB] = 1; v[ALU_ADD] = 1; v[LOAD_ALU] = 1; v[LOAD_DOR] = writes;
        end
        if (step >= 3 && step <= 5) begin v[SET_SB_TO_ALU] = 1; v[LOAD_SP] = 1; end
        case (step)
            2: v[SET_DB_TO_PCH] = 1;
            3: v[SET_DB_TO_PCL] = 1;
            4: begin v[SET_DB_TO_PSR] = 1; v[SET_PSR_OUTPUT_BRK_HIGH] = (s == M_BRK); end
            5: begin
                v[SET_ADL_FA] = (s == M_NMI); v[SET_ADL_FC] = (s == M_RST); v[SET_ADL_FE] = irqv;
                v[SET_ADH_FF] = 1; v[LOAD_ABL] = 1; v[LOAD_ABH] = 1; v[LOAD_INTERUPT_PSR_FLAG] = 1;
            end
            6: begin
                v[SET_DB_TO_DATA] = 1; v[SET_INPUT_B_TO_DB] = 1; v[SET_INPUT_A_TO_LOW] = 1;
                v[ALU_ADD] = 1; v[LOAD_ALU] = 1; v[LOAD_ABL] = 1;
                v[SET_ADL_FB] = (s == M_NMI); v[SET_ADL_FD] = (s == M_RST); v[SET_ADL_FF] = irqv;
            end
            7: begin v[SET_ADL_TO_ALU] = 1; v[SET_ADH_TO_DATA] = 1; v[LOAD_PC] = 1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic cmp_model();
        chk("model.busy", 128'(busy), 128'(m_step != 0));
        chk("model.vector_sel", 128'(vector_sel), 128'(m_vec(m_src)));
        chk("model.mem_write", 128'(mem_write), 128'(m_step >= 2 && m_step <= 4 && m_src != M_RST));
        chk("model.seq_done", 128'(seq_done), 128'(m_step == 7));
        chk("model.flags", 128'(flags_out), 128'(m_flags(m_step, m_src)));
    endtask

    task automatic cyc(input bit r, input bit n, input bit i, input bit b, input bit ib, input bit p);
        @(negedge clk);
        rst = r; nmi = n; irq = i; brk_req = b; instr_boundary = ib; psr_i = p;
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".busy"}, 128'(busy), 128'(0));
        chk({name, ".mem_write"}, 128'(mem_write), 128'(0));
        chk({name, ".seq_done"}, 128'(seq_done), 128'(0));
        chk({name, ".vector_sel"}, 128'(vector_sel), 128'(0));
        chk({name, ".flags"}, 128'(flags_out), 128'(0));
    endtask

    typedef struct {
        bit r, n, i, b, ib, p;
        bit busy; bit [1:0] vsel; bit mw, done;
        int fidx; bit fval;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst = 1; nmi = 0; irq = 0; brk_req = 0; instr_boundary = 0; psr_i = 0;
        model_reset();

        // Reset release sequence, then an unmasked IRQ sequence.
        tbl[0]  = '{0,0,0,0,0,0, 1,2'd2,0,0, SET_ADL_TO_SP, 1};
        tbl[1]  = '{0,0,0,0,0,0, 1,2'd2,0,0, LOAD_DOR, 0};
        tbl[2]  = '{0,0,0,0,0,0, 1,2'd2,0,0, LOAD_SP, 1};
        tbl[3]  = '{0,0,0,0,0,0, 1,2'd2,0,0, SET_DB_TO_PSR, 1};
        tbl[4]  = '{0,0,0,0,0,0, 1,2'd2,0,0, SET_ADL_FC, 1};
        tbl[5]  = '{0,0,0,0,0,0, 1,2'd2,0,0, SET_ADL_FD, 1};
        tbl[6]  = '{0,0,0,0,0,0, 1,2'd2,0,1, LOAD_PC, 1};
        tbl[7]  = '{0,0,0,0,0,0, 0,2'd0,0,0, LOAD_PC, 0};
        tbl[8]  = '{0,0,1,0,1,0, 1,2'd3,0,0, LOAD_ABH, 1};
        tbl[9]  = '{0,0,1,0,0,0, 1,2'd3,1,0, SET_DB_TO_PCH, 1};
        tbl[10] = '{0,0,1,0,0,0, 1,2'd3,1,0, SET_DB_TO_PCL, 1};
        tbl[11] = '{0,0,1,0,0,0, 1,2'd3,1,0, SET_PSR_OUTPUT_BRK_HIGH, 0};
        tbl[12] = '{0,0,1,0,0,0, 1,2'd3,0,0, LOAD_INTERUPT_PSR_FLAG, 1};
        tbl[13] = '{0,0,1,0,0,0, 1,2'd3,0,0, SET_ADL_FF, 1};
        tbl[14] = '{0,0,1,0,0,0, 1,2'd3,0,1, SET_ADH_TO_DATA, 1};
        tbl[15] = '{0,0,0,0,0,0, 0,2'd0,0,0, SET_ADL_TO_ALU, 0};

        repeat (2) @(posedge clk);
        #1 chk_zero("reset");

        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].n, tbl[k].i, tbl[k].b, tbl[k].ib, tbl[k].p);
            chk($sformatf("tbl%0d.busy", k), 128'(busy), 128'(tbl[k].busy));
            chk($sformatf("tbl%0d.vsel", k), 128'(vector_sel), 128'(tbl[k].vsel));
            chk($sformatf("tbl%0d.mw", k), 128'(mem_write), 128'(tbl[k].mw));
            chk($sformatf("tbl%0d.done", k), 128'(seq_done), 128'(tbl[k].done));
            chk($sformatf("tbl%0d.flag%0d", k, tbl[k].fidx), 128'(flags_out[tbl[k].fidx]), 128'(tbl[k].fval));
        end

        // Masked IRQ at every boundary.
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 1, 0, 1, 1);
            chk("masked_irq.busy", 128'(busy), 128'(0));
        end

        // BRK is not masked by psr_i.
        cyc(0, 0, 0, 1, 1, 1);
        chk("brk.vsel", 128'(vector_sel), 128'(3));
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        chk("brk.brk_bit", 128'(flags_out[SET_PSR_OUTPUT_BRK_HIGH]), 128'(1));
        cyc(0, 0, 0, 0, 0, 1);
        chk("brk.fe", 128'(flags_out[SET_ADL_FE]), 128'(1));
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("brk.idle", 128'(busy), 128'(0));

        // NMI edge and IRQ together: NMI wins, then IRQ at the next boundary.
        cyc(0, 1, 1, 0, 1, 0);
        chk("nmi_irq.vsel", 128'(vector_sel), 128'(1));
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("nmi_irq.fa", 128'(flags_out[SET_ADL_FA]), 128'(1));
        repeat (2) cyc(0, 1, 1, 0, 0, 0);
        chk("nmi_irq.done", 128'(seq_done), 128'(1));
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 0);
        chk("irq_after_nmi.vsel", 128'(vector_sel), 128'(3));
        repeat (7) cyc(0, 0, 0, 0, 0, 0);

        // BRK hijacked by an NMI edge arriving during PUSH_PCL.
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("hijack.brk_bit", 128'(flags_out[SET_PSR_OUTPUT_BRK_HIGH]), 128'(1));
        chk("hijack.vsel_psr", 128'(vector_sel), 128'(3));
        cyc(0, 1, 0, 0, 0, 0);
        chk("hijack.fa", 128'(flags_out[SET_ADL_FA]), 128'(1));
        chk("hijack.fe", 128'(flags_out[SET_ADL_FE]), 128'(0));
        chk("hijack.vsel", 128'(vector_sel), 128'(1));
        cyc(0, 1, 0, 0, 0, 0);
        chk("hijack.fb", 128'(flags_out[SET_ADL_FB]), 128'(1));
        repeat (2) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("hijack.cleared", 128'(busy), 128'(0));

        // Reset asserted mid-sequence.
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("abort.in_pcl", 128'(flags_out[SET_DB_TO_PCL]), 128'(1));
        @(negedge clk);
        #2 rst = 1;
        #1 model_reset();
        chk_zero("abort");
        cyc(0, 0, 0, 0, 0, 0);
        chk("abort.restart_vsel", 128'(vector_sel), 128'(2));
        repeat (6) cyc(0, 0, 0, 0, 0, 0);
        chk("abort.restart_done", 128'(seq_done), 128'(1));

        // Random traffic against the model.
        begin
            bit n = 0;
            for (int k = 0; k < 3000; k++) begin
                bit r, ib;
                r = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 7) == 0) n = ~n;
                ib = ($urandom_range(0, 3) == 0);
                cyc(r, n, $urandom_range(0, 2) == 0, ib && ($urandom_range(0, 2) == 0),
                    ib, $urandom_range(0, 1) == 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
